// File: rtl/clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// clk_mon_pkg
// Shared definitions for the clock-lock supervisor and its frequency meter.
//   SYNC_STAGES : depth of the synchronisers on every asynchronous status input
//   state_t     : supervisor FSM encoding
// -----------------------------------------------------------------------------
package clk_mon_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        HOLD_RST  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

endpackage

// File: rtl/clk_freq_meter.sv
// -----------------------------------------------------------------------------
// clk_freq_meter
// Windowed edge counter for the divided-down CLK_OUT toggle. Every WIN_CYC
// system-clock cycles the number of toggle edges seen in the window is
// published on freq_count, and freq_ok reports whether it lies within
// EXP_EDGES +/- TOL.
// Ports:
//   clk        in   free-running system clock
//   reset      in   synchronous, active-high
//   toggle     in   asynchronous toggle from the CLK_OUT domain
//   freq_count out  edges counted in the last completed window
//   freq_ok    out  last window within tolerance
// -----------------------------------------------------------------------------
module clk_freq_meter
    import clk_mon_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int WIN_CYC   = 1024,
    parameter int EXP_EDGES = 410,
    parameter int TOL       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             toggle,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_ok
);

    localparam logic [31:0] LO_BOUND = (EXP_EDGES > TOL) ? 32'(EXP_EDGES - TOL) : 32'd0;
    localparam logic [31:0] HI_BOUND = 32'(EXP_EDGES + TOL);

    logic [SYNC_STAGES-1:0] toggle_sync;
    logic                   toggle_s;
    logic                   toggle_prev;
    logic                   edge_seen;
    logic                   in_band;
    logic [CNT_W-1:0]       win_cnt;
    logic [CNT_W-1:0]       edge_cnt;

    assign toggle_s  = toggle_sync[SYNC_STAGES-1];
    assign edge_seen = toggle_s ^ toggle_prev;
    assign in_band   = (32'(edge_cnt) >= LO_BOUND) && (32'(edge_cnt) <= HI_BOUND);

    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_sync <= '0;
            toggle_prev <= 1'b0;
            win_cnt     <= '0;
            edge_cnt    <= '0;
            freq_count  <= '0;
            freq_ok     <= 1'b0;
        end else begin
            toggle_sync <= {toggle_sync[SYNC_STAGES-2:0], toggle};
            toggle_prev <= toggle_s;
            if (win_cnt == CNT_W'(WIN_CYC - 1)) begin
                win_cnt    <= '0;
                freq_count <= edge_cnt;
                freq_ok    <= in_band;
                // An edge landing on the closing cycle belongs to the next window.
                edge_cnt   <= edge_seen ? CNT_W'(1) : '0;
            end else begin
                win_cnt <= win_cnt + CNT_W'(1);
                if (edge_seen && (edge_cnt != '1)) begin
                    edge_cnt <= edge_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clk_lock_supervisor.sv
// -----------------------------------------------------------------------------
// clk_lock_supervisor
// Sequences the MMCM reset of clk_wiz_0, retries on lock timeout, and releases
// a reset to CLK_OUT consumers only after lock has been stable. Counts lock
// losses while running and monitors CLK_OUT frequency through clk_freq_meter.
// Ports:
//   clk               in   free-running system clock
//   reset             in   synchronous, active-high
//   locked            in   MMCM locked (async, synchronised here)
//   input_clk_stopped in   MMCM input clock stopped (async, synchronised here)
//   clk_out_toggle    in   CLK_OUT/8 toggle (async, synchronised in the meter)
//   mmcm_reset        out  reset request to the clocking wizard
//   rst_out           out  reset for CLK_OUT consumers, 1 = held
//   run               out  1 while in RUN
//   fail              out  retries exhausted, held until reset
//   stopped_seen      out  input clock stop seen in RUN, held until reset
//   lock_loss_cnt     out  lock losses in RUN, saturating
//   freq_count        out  edges counted in last completed window
//   freq_ok           out  last window within tolerance
// -----------------------------------------------------------------------------
module clk_lock_supervisor
    import clk_mon_pkg::*;
#(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int STABLE_CYC   = 256,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16,
    parameter int WIN_CYC      = 1024,
    parameter int EXP_EDGES    = 410,
    parameter int TOL          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    input  logic             input_clk_stopped,
    input  logic             clk_out_toggle,
    output logic             mmcm_reset,
    output logic             rst_out,
    output logic             run,
    output logic             fail,
    output logic             stopped_seen,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_ok
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    logic [SYNC_STAGES-1:0] locked_sync;
    logic [SYNC_STAGES-1:0] stopped_sync;
    logic                   locked_s;
    logic                   stopped_s;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   timer_next;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_next;
    logic               loss_event;
    logic               stop_event;

    assign locked_s  = locked_sync[SYNC_STAGES-1];
    assign stopped_s = stopped_sync[SYNC_STAGES-1];

    // One timer serves every state: pulse length in HOLD_RST, timeout in
    // WAIT_LOCK, and the consecutive-locked count in STABLE.
    always_comb begin
        state_next = state;
        timer_next = timer + CNT_W'(1);
        retry_next = retry;
        loss_event = 1'b0;
        stop_event = 1'b0;
        case (state)
            HOLD_RST: begin
                if (timer == CNT_W'(RST_PULSE - 1)) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    // This locked cycle is the first one counted.
                    state_next = STABLE;
                    timer_next = CNT_W'(1);
                end else if (timer == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    timer_next = '0;
                    retry_next = retry + RETRY_W'(1);
                    state_next = (retry_next == RETRY_W'(MAX_RETRY)) ? FAIL : HOLD_RST;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (timer == CNT_W'(STABLE_CYC - 1)) begin
                    state_next = RUN;
                    timer_next = '0;
                    retry_next = '0;
                end
            end
            RUN: begin
                timer_next = '0;
                // A stop and a lock drop together are one event.
                if (!locked_s || stopped_s) begin
                    state_next = HOLD_RST;
                    loss_event = 1'b1;
                    stop_event = stopped_s;
                end
            end
            FAIL: begin
                timer_next = '0;
            end
            default: begin
                state_next = HOLD_RST;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_sync   <= '0;
            stopped_sync  <= '0;
            state         <= HOLD_RST;
            timer         <= '0;
            retry         <= '0;
            mmcm_reset    <= 1'b1;
            rst_out       <= 1'b1;
            run           <= 1'b0;
            fail          <= 1'b0;
            stopped_seen  <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            locked_sync  <= {locked_sync[SYNC_STAGES-2:0], locked};
            stopped_sync <= {stopped_sync[SYNC_STAGES-2:0], input_clk_stopped};
            state        <= state_next;
            timer        <= timer_next;
            retry        <= retry_next;
            mmcm_reset   <= (state_next == HOLD_RST);
            rst_out      <= (state_next != RUN);
            run          <= (state_next == RUN);
            fail         <= (state_next == FAIL);
            if (stop_event) begin
                stopped_seen <= 1'b1;
            end
            if (loss_event && (lock_loss_cnt != '1)) begin
                lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
            end
        end
    end

    clk_freq_meter #(
        .CNT_W     (CNT_W),
        .WIN_CYC   (WIN_CYC),
        .EXP_EDGES (EXP_EDGES),
        .TOL       (TOL)
    ) u_freq_meter (
        .clk        (clk),
        .reset      (reset),
        .toggle     (clk_out_toggle),
        .freq_count (freq_count),
        .freq_ok    (freq_ok)
    );

endmodule

// File: tb/tb_clk_lock_supervisor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_clk_lock_supervisor
// Directed bench for clk_lock_supervisor. The 100 MHz system clock runs with
// posedges at 5 mod 10 ns; stimulus is driven and outputs are sampled on the
// falling edge. The CLK_OUT toggle is generated with a 2 ns phase offset so
// its edges never coincide with a system-clock posedge.
// -----------------------------------------------------------------------------
module tb_clk_lock_supervisor;
    import clk_mon_pkg::*;

    localparam int CNT_W = 16;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    logic locked;
    logic input_clk_stopped;
    logic clk_out_toggle;

    logic             mmcm_reset;
    logic             rst_out;
    logic             run;
    logic             fail;
    logic             stopped_seen;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [CNT_W-1:0] freq_count;
    logic             freq_ok;

    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    logic tog_en   = 1'b0;
    real  tog_half = 25.0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_lock_supervisor u_dut (
        .clk               (clk),
        .reset             (reset),
        .locked            (locked),
        .input_clk_stopped (input_clk_stopped),
        .clk_out_toggle    (clk_out_toggle),
        .mmcm_reset        (mmcm_reset),
        .rst_out           (rst_out),
        .run               (run),
        .fail              (fail),
        .stopped_seen      (stopped_seen),
        .lock_loss_cnt     (lock_loss_cnt),
        .freq_count        (freq_count),
        .freq_ok           (freq_ok)
    );

    // CLK_OUT/8 toggle source: edge spacing tog_half ns while enabled.
    initial begin
        clk_out_toggle = 1'b0;
        forever begin
            wait (tog_en);
            #2;
            while (tog_en) begin
                #(tog_half) clk_out_toggle = ~clk_out_toggle;
            end
        end
    end

    // checker
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_mmcm(input string tag, input logic lvl, input int limit);
        int n = 0;
        while (mmcm_reset !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(mmcm_reset), 32'(lvl));
    endtask

    task automatic wait_run(input string tag, input int limit);
        int n = 0;
        while (run !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(run), 32'd1);
    endtask

    // Cycles from a locked rise (driven at a negedge) until rst_out is seen low.
    task automatic measure_release(output int n);
        n = 0;
        while (rst_out !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Length of the mmcm_reset pulse that is currently high.
    task automatic measure_pulse(output int n);
        n = 0;
        while (mmcm_reset === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int f1, f2, f3;
        logic r2, r3;

        reset             = 1'b1;
        locked            = 1'b0;
        input_clk_stopped = 1'b0;

        // ---- 1: power-up, lock at cycle 100 ----
        repeat (20) @(negedge clk);
        check_eq("rst_mmcm_reset",   32'(mmcm_reset),   32'd1);
        check_eq("rst_rst_out",      32'(rst_out),      32'd1);
        check_eq("rst_run",          32'(run),          32'd0);
        check_eq("rst_fail",         32'(fail),         32'd0);
        check_eq("rst_stopped_seen", 32'(stopped_seen), 32'd0);
        check_eq("rst_loss_cnt",     32'(lock_loss_cnt), 32'd0);
        check_eq("rst_freq_count",   32'(freq_count),   32'd0);
        check_eq("rst_freq_ok",      32'(freq_ok),      32'd0);
        reset = 1'b0;
        measure_pulse(n);
        check_eq("t1_first_pulse_len", 32'(n), 32'd16);
        repeat (100 - 20 - 16) @(negedge clk);
        locked = 1'b1;
        measure_release(n);
        // 2 sync cycles + 256 consecutive locked cycles
        check_eq("t1_release_latency", 32'(n), 32'd258);
        check_eq("t1_run", 32'(run), 32'd1);
        check_eq("t1_mmcm_low", 32'(mmcm_reset), 32'd0);

        // ---- 4: lock loss in RUN ----
        locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        r2 = rst_out;
        @(negedge clk);
        r3 = rst_out;
        check_eq("t4_rst_out_cyc2", 32'(r2), 32'd0);
        check_eq("t4_rst_out_cyc3", 32'(r3), 32'd1);
        check_eq("t4_run_low", 32'(run), 32'd0);
        check_eq("t4_loss_cnt", 32'(lock_loss_cnt), 32'd1);
        check_eq("t4_stopped_clear", 32'(stopped_seen), 32'd0);
        measure_pulse(n);
        check_eq("t4_pulse_len", 32'(n), 32'd16);
        locked = 1'b1;
        wait_run("t4_relock_run", 600);

        // ---- 5: stop and lock drop together ----
        input_clk_stopped = 1'b1;
        locked            = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t5_stopped_seen", 32'(stopped_seen), 32'd1);
        check_eq("t5_loss_cnt", 32'(lock_loss_cnt), 32'd2);
        check_eq("t5_rst_out", 32'(rst_out), 32'd1);
        input_clk_stopped = 1'b0;
        locked            = 1'b1;
        wait_run("t5_relock_run", 600);
        check_eq("t5_loss_cnt_hold", 32'(lock_loss_cnt), 32'd2);

        // ---- 3: lock glitch during STABLE ----
        locked = 1'b0;
        apply_reset(5);
        check_eq("t3_sticky_cleared", 32'(stopped_seen), 32'd0);
        check_eq("t3_loss_cleared", 32'(lock_loss_cnt), 32'd0);
        reset = 1'b0;
        wait_mmcm("t3_pulse_end", 1'b0, 100);
        locked = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("t3_in_stable", 32'(u_dut.state), 32'(STABLE));
        locked = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t3_back_wait_lock", 32'(u_dut.state), 32'(WAIT_LOCK));
        check_eq("t3_rst_out_held", 32'(rst_out), 32'd1);
        locked = 1'b1;
        measure_release(n);
        check_eq("t3_full_restart", 32'(n), 32'd258);

        // ---- 2: lock never arrives ----
        locked = 1'b0;
        apply_reset(5);
        reset = 1'b0;
        wait_mmcm("t2_fall1", 1'b0, 100);
        f1 = cyc;
        wait_mmcm("t2_rise2", 1'b1, 5000);
        wait_mmcm("t2_fall2", 1'b0, 100);
        f2 = cyc;
        wait_mmcm("t2_rise3", 1'b1, 5000);
        wait_mmcm("t2_fall3", 1'b0, 100);
        f3 = cyc;
        check_eq("t2_period_1_2", 32'(f2 - f1), 32'd4112);
        check_eq("t2_period_2_3", 32'(f3 - f2), 32'd4112);
        n = 0;
        while (fail !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("t2_fail_delay", 32'(cyc - f3), 32'd4096);
        check_eq("t2_fail_rst_out", 32'(rst_out), 32'd1);
        check_eq("t2_fail_mmcm", 32'(mmcm_reset), 32'd0);
        repeat (200) @(negedge clk);
        check_eq("t2_fail_sticky", 32'(fail), 32'd1);
        check_eq("t2_no_4th_pulse", 32'(mmcm_reset), 32'd0);
        apply_reset(3);
        check_eq("t2_fail_cleared", 32'(fail), 32'd0);

        // ---- 6: frequency meter ----
        reset    = 1'b0;
        tog_half = 25.0;
        tog_en   = 1'b1;
        repeat (2200) @(negedge clk);
        check_eq("t6_40m_count_in_409_410",
                 32'((freq_count >= 16'd409) && (freq_count <= 16'd410)), 32'd1);
        check_eq("t6_40m_ok", 32'(freq_ok), 32'd1);
        tog_half = 50.0;
        repeat (2200) @(negedge clk);
        check_eq("t6_20m_count_in_204_205",
                 32'((freq_count >= 16'd204) && (freq_count <= 16'd205)), 32'd1);
        check_eq("t6_20m_ok", 32'(freq_ok), 32'd0);
        tog_half = 25.0;
        repeat (2200) @(negedge clk);
        check_eq("t6_40m_ok_again", 32'(freq_ok), 32'd1);
        repeat (300) @(negedge clk);
        apply_reset(2);
        check_eq("t6_midwin_reset_count", 32'(freq_count), 32'd0);
        check_eq("t6_midwin_reset_ok", 32'(freq_ok), 32'd0);
        tog_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
